// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
// Holds the FSM state type and chunk-count / index-width helpers.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } adder_state_e;

    // Number of cycles an operation spends in BUSY.
    function automatic int chunk_count(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // Chunk index width, never narrower than one bit.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    // Index width for the default 16-bit / 4-bit configuration.
    localparam int DEF_IDX_W = idx_width(chunk_count(16, 4));

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice, time-multiplexed by the top.
// Also exposes the carry into its MSB so the top can derive overflow.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] full;

    // Plain ripple sum; carry into the MSB falls out of the sum bit.
    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        sum  = full[CHUNK-1:0];
        cout = full[CHUNK];
        cmsb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/sub, CHUNK bits per clock, LSB chunk first.
// Optional saturation on signed overflow: SEQ_CHUNK_ADDER_SAT_EN.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             busy
);

    localparam int NCHUNK = chunk_count(WIDTH, CHUNK);
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || (WIDTH % CHUNK != 0)) begin : g_bad
            $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    adder_state_e     state;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] s_c;
    logic             c_out;
    logic             c_msb;
    logic             last;
    logic             ovf_nx;
    logic [WIDTH-1:0] sum_nx;
    int unsigned      off;

`ifdef SEQ_CHUNK_ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] SMAX = ~SMIN;
`endif

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (a_c),
        .b    (b_c),
        .cin  (carry_q),
        .sum  (s_c),
        .cout (c_out),
        .cmsb (c_msb)
    );

    assign last   = (idx == LAST);
    assign ovf_nx = c_msb ^ c_out;

    // Select the active chunk and merge its sum into the result.
    always_comb begin
        off    = 32'(idx) * 32'(CHUNK);
        a_c    = a_q[off +: CHUNK];
        b_c    = b_q[off +: CHUNK];
        sum_nx = sum_q;
        sum_nx[off +: CHUNK] = s_c;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
        if (last && ovf_nx) begin
            if (!a_q[WIDTH-1] && !b_q[WIDTH-1])
                sum_nx = SMAX;
            else
                sum_nx = SMIN;
        end
`endif
    end

    // Handshake FSM plus the per-chunk datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? ~carryin : carryin;
                        idx     <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    sum_q   <= sum_nx;
                    carry_q <= c_out;
                    idx     <= idx + IDX_W'(1);
                    if (last) begin
                        cout_q <= c_out;
                        ovf_q  <= ovf_nx;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_q;
    assign carryout  = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder (WIDTH=16, CHUNK=4).
// Directed plan cases followed by random operations against a model.
module tb_seq_chunk_adder;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int NC = W / C;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carryin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carryout;
    logic         overflow;
    logic         busy;

    int errors = 0;
    int checks = 0;

    seq_chunk_adder #(
        .WIDTH (W),
        .CHUNK (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carryin   (carryin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carryout  (carryout),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on the true mathematical result.
    function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                  input logic tc, input logic ts,
                                  output logic [W-1:0] sm, output logic co,
                                  output logic ov);
        int ua;
        int ub;
        int sa;
        int sb;
        int ur;
        int r;
        ua = int'(ta);
        ub = int'(tb);
        sa = int'($signed(ta));
        sb = int'($signed(tb));
        if (!ts) begin
            ur = ua + ub + int'(tc);
            r  = sa + sb + int'(tc);
            co = (ur > 65535);
        end else begin
            ur = ua - ub - int'(tc);
            r  = sa - sb - int'(tc);
            co = (ur >= 0);
        end
        sm = ur[W-1:0];
        ov = (r > 32767) || (r < -32768);
`ifdef SEQ_CHUNK_ADDER_SAT_EN
        if (ov) sm = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
    endfunction

    // One full operation: accept, latency, result, hold, release.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts, input int hold);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        int           n;
        model(ta, tb, tc, ts, es, ec, eo);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        a = ta;
        b = tb;
        carryin = tc;
        sub = ts;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 3 * NC) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 32'(n), 32'(NC));
        chk("sum", 32'(sum), 32'(es));
        chk("carryout", 32'(carryout), 32'(ec));
        chk("overflow", 32'(overflow), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_sum", 32'(sum), 32'(es));
            chk("hold_flags", {30'd0, carryout, overflow}, {30'd0, ec, eo});
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_flags", {30'd0, carryout, overflow}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_op(16'h000A, 16'h0002, 1'b1, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 2);
        run_op(16'h1357, 16'h2468, 1'b1, 1'b1, 10);

        // Abort during the second BUSY cycle.
        @(negedge clk);
        a = 16'h4321;
        b = 16'h1111;
        carryin = 1'b0;
        sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (NC + 2) begin
            @(posedge clk);
            #1;
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 5 == 0) rb = 16'h8000 ^ ra;
            run_op(ra, rb, 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
